// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bus arbiter and its DMA sequencer.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam int DMA_LEN_DEFAULT = 160;

endpackage

// File: rtl/cart_dma_seq.sv
// OAM DMA sequencer: tracks the active transfer, its source page and byte index,
// and handles restarts that land while a DMA byte is still on the bus.
module cart_dma_seq
  import cart_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  input  logic        byte_done,
  input  logic        in_flight,
  output logic        active,
  output logic        req,
  output logic [15:0] addr
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic [7:0] src_hi;
  logic [7:0] idx;
  logic       restart_pend;

  // A start arriving mid-byte must not let that byte's completion advance the fresh index.
  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      active       <= 1'b0;
      src_hi       <= 8'h00;
      idx          <= 8'h00;
      restart_pend <= 1'b0;
    end else if (dma_start) begin
      active       <= 1'b1;
      src_hi       <= dma_src_hi;
      idx          <= 8'h00;
      restart_pend <= in_flight;
    end else if (byte_done) begin
      if (restart_pend) begin
        restart_pend <= 1'b0;
      end else if (idx == LAST_IDX) begin
        active <= 1'b0;
        idx    <= 8'h00;
      end else begin
        idx <= idx + 8'd1;
      end
    end
  end

  // A start pulse is visible to the arbiter in the same cycle, ahead of the latched page.
  assign req  = dma_start | active;
  assign addr = dma_start ? {dma_src_hi, 8'h00} : {src_hi, idx};

endmodule

// File: rtl/cart_bus_arb.sv
// Cartridge bus arbiter: grants cart-space accesses to the CPU or the OAM DMA,
// issues one-cycle rd/wr strobes, waits out the interface busy and returns data.
module cart_bus_arb
  import cart_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  output logic        dma_active,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_din,
  output logic        cart_rd,
  output logic        cart_wr,
  input  logic        cart_busy,
  input  logic [7:0]  cart_dout
);

  arb_state_t  state, state_nx;
  owner_t      owner, owner_nx;
  logic        is_rd, is_rd_nx;
  logic [15:0] cart_addr_nx;
  logic [7:0]  cart_din_nx;
  logic        cart_rd_nx, cart_wr_nx;
  logic [7:0]  cpu_dout_nx;
  logic        cpu_ack_nx;
  logic        oam_we_nx;
  logic [7:0]  oam_addr_nx, oam_data_nx;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        byte_done;
  logic        dma_in_flight;

  assign dma_in_flight = (owner == OWN_DMA) && ((state == ISSUE) || (state == WAIT));
  assign byte_done     = (state == DONE) && (owner == OWN_DMA);
  assign cpu_busy      = (cpu_rd | cpu_wr) & ~cpu_ack;

  cart_dma_seq #(
    .DMA_LEN(DMA_LEN)
  ) u_dma_seq (
    .clk_8m    (clk_8m),
    .rst_n     (rst_n),
    .dma_start (dma_start),
    .dma_src_hi(dma_src_hi),
    .byte_done (byte_done),
    .in_flight (dma_in_flight),
    .active    (dma_active),
    .req       (dma_req),
    .addr      (dma_addr)
  );

  // Next-state and next-output logic; every output is computed here one cycle early so it leaves a flop.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    is_rd_nx     = is_rd;
    cart_addr_nx = cart_addr;
    cart_din_nx  = cart_din;
    cart_rd_nx   = 1'b0;
    cart_wr_nx   = 1'b0;
    cpu_dout_nx  = cpu_dout;
    cpu_ack_nx   = 1'b0;
    oam_we_nx    = 1'b0;
    oam_addr_nx  = oam_addr;
    oam_data_nx  = oam_data;

    case (state)
      IDLE: begin
        if (dma_req) begin
          owner_nx     = OWN_DMA;
          is_rd_nx     = 1'b1;
          cart_addr_nx = dma_addr;
          cart_rd_nx   = 1'b1;
          state_nx     = ISSUE;
        end else if (cpu_rd) begin
          owner_nx     = OWN_CPU;
          is_rd_nx     = 1'b1;
          cart_addr_nx = cpu_addr;
          cart_rd_nx   = 1'b1;
          state_nx     = ISSUE;
        end else if (cpu_wr) begin
          owner_nx     = OWN_CPU;
          is_rd_nx     = 1'b0;
          cart_addr_nx = cpu_addr;
          cart_din_nx  = cpu_din;
          cart_wr_nx   = 1'b1;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (!cart_busy) begin
          state_nx = DONE;
          if (owner == OWN_CPU) begin
            cpu_ack_nx = 1'b1;
            if (is_rd) begin
              cpu_dout_nx = cart_dout;
            end
          end else begin
            oam_we_nx   = 1'b1;
            oam_addr_nx = cart_addr[7:0];
            oam_data_nx = cart_dout;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons whatever transaction was in progress.
  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      is_rd     <= 1'b0;
      cart_addr <= 16'h0000;
      cart_din  <= 8'h00;
      cart_rd   <= 1'b0;
      cart_wr   <= 1'b0;
      cpu_dout  <= 8'hFF;
      cpu_ack   <= 1'b0;
      oam_we    <= 1'b0;
      oam_addr  <= 8'h00;
      oam_data  <= 8'h00;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      is_rd     <= is_rd_nx;
      cart_addr <= cart_addr_nx;
      cart_din  <= cart_din_nx;
      cart_rd   <= cart_rd_nx;
      cart_wr   <= cart_wr_nx;
      cpu_dout  <= cpu_dout_nx;
      cpu_ack   <= cpu_ack_nx;
      oam_we    <= oam_we_nx;
      oam_addr  <= oam_addr_nx;
      oam_data  <= oam_data_nx;
    end
  end

endmodule
